// File: rtl/adc_decimator_if.sv
// rtl/adc_decimator_if.sv - sample input, averaged output and status bundle for adc_decimator
interface adc_decimator_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]      in_data;
    logic             in_valid;
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             clear_overflow;

    modport master (
        output in_data, in_valid, out_ready, clear_overflow,
        input  out_data, out_valid, fifo_level, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready, clear_overflow,
        output out_data, out_valid, fifo_level, overflow
    );
endinterface

// File: rtl/adc_decimator.sv
// rtl/adc_decimator.sv - accumulate-and-dump boxcar decimator with FWFT output FIFO
module adc_decimator #(
    parameter int DECIM      = 4,
    parameter int LOG2_DECIM = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    adc_decimator_if.slave bus
);
    localparam int ACC_W = 16 + LOG2_DECIM;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LOG2_DECIM-1:0] LAST_PHASE = LOG2_DECIM'(DECIM - 1);
    localparam logic [LVL_W-1:0]      FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    logic [LOG2_DECIM-1:0]   phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sample_ext, sum;
    logic [15:0]             result;
    logic [15:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_q, rd_d, wr_q, wr_d, rd_inc;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [15:0]             head_q, head_d;
    logic                    ovf_q, ovf_d;
    logic                    block_done, full, pop, do_push, drop;

    always_comb begin
        sample_ext = {{LOG2_DECIM{bus.in_data[15]}}, bus.in_data};
        sum        = acc_q + sample_ext;
        // Top 16 bits of the sum are the floor-averaged result (arithmetic shift by LOG2_DECIM).
        result     = sum[ACC_W-1:LOG2_DECIM];
        block_done = bus.in_valid && (phase_q == LAST_PHASE);
        full       = (level_q == FULL_LEVEL);
        pop        = (level_q != '0) && bus.out_ready;
        do_push    = block_done && (!full || pop);
        drop       = block_done && full && !pop;
        rd_inc     = rd_q + PTR_W'(1);
    end

    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        if (bus.in_valid) begin
            phase_d = phase_q + LOG2_DECIM'(1);
            acc_d   = (phase_q == '0) ? sample_ext : sum;
        end

        rd_d    = pop ? rd_inc : rd_q;
        wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
        level_d = level_q + LVL_W'(do_push) - LVL_W'(pop);

        // Head register mirrors the FIFO front and keeps the last popped value once empty.
        head_d = head_q;
        if (pop && (level_q > LVL_W'(1)))
            head_d = mem_q[rd_inc];
        else if (do_push && ((level_q == '0) || pop))
            head_d = result;

        ovf_d = drop ? 1'b1 : (bus.clear_overflow ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            acc_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem_q[wr_q] <= result;
    end

    assign bus.out_data   = head_q;
    assign bus.out_valid  = (level_q != '0);
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_adc_decimator.sv
// tb/tb_adc_decimator.sv - randomized self-checking bench for adc_decimator
module tb_adc_decimator;
    localparam int DECIM = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adc_decimator_if #(.FIFO_DEPTH(DEPTH)) bus();

    adc_decimator #(.DECIM(DECIM), .LOG2_DECIM(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_q[$];
    int m_sum, m_cnt, m_last;
    bit m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_sum  = 0;
        m_cnt  = 0;
        m_last = 0;
        m_ovf  = 0;
    endtask

    function automatic int floor_avg(input int s);
        int q;
        q = s / DECIM;
        if (s < 0 && (s % DECIM) != 0) q -= 1;
        return q;
    endfunction

    // One clock: drive at negedge, advance the model over the edge, return 1 time unit after it.
    task automatic cyc(input bit v, input int d, input bit rdy, input bit clr);
        bit pop, drop;
        int r;
        @(negedge clk);
        bus.in_valid       = v;
        bus.in_data        = 16'(d);
        bus.out_ready      = rdy;
        bus.clear_overflow = clr;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            pop  = (m_q.size() > 0) && rdy;
            drop = 0;
            if (pop) m_last = m_q.pop_front();
            if (v) begin
                m_sum += d;
                m_cnt++;
                if (m_cnt == DECIM) begin
                    r = floor_avg(m_sum);
                    m_sum = 0;
                    m_cnt = 0;
                    if (m_q.size() < DEPTH) m_q.push_back(r);
                    else drop = 1;
                end
            end
            if (drop) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cyc($urandom_range(0, 1), int'($urandom_range(0, 65535)) - 32768, 1'b1, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd0 || bus.fifo_level !== 3'd0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%b data=%0d level=%0d ovf=%b, required 0/0/0/0",
                     bus.out_valid, bus.out_data, bus.fifo_level, bus.overflow);
        end
    endtask

    task automatic test_basic();
        int samples[4] = '{1, 2, 3, 4};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, samples[i], 1'b1, 1'b0);
            if (i < 3) begin
                repeat (99) cyc(1'b0, 0, 1'b1, 1'b0);
            end
        end
        n_tests++;
        if (bus.out_valid !== 1'b1 || $signed(bus.out_data) !== 16'sd2) begin
            n_fail++;
            $display("FAIL basic_out: valid=%b data=%0d, required 1/2", bus.out_valid, $signed(bus.out_data));
        end
        cyc(1'b0, 0, 1'b1, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b0 || $signed(bus.out_data) !== 16'sd2) begin
            n_fail++;
            $display("FAIL basic_one_cycle: valid=%b data=%0d, required 0/2", bus.out_valid, $signed(bus.out_data));
        end
    endtask

    task automatic test_extremes();
        int vals[3][4] = '{'{-1, -2, -3, -4}, '{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}};
        int exp[3]     = '{-3, 32767, -32768};
        logic [15:0] e16;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) cyc(1'b1, vals[b][i], 1'b1, 1'b0);
            e16 = 16'(exp[b]);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e16) begin
                n_fail++;
                $display("FAIL extreme_%0d: valid=%b data=%0d, required 1/%0d", b, bus.out_valid, $signed(bus.out_data), exp[b]);
            end
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i < 4) ? 10 : 20, 1'b1, 1'b0);
            if (i == 3) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd10) begin
                    n_fail++;
                    $display("FAIL b2b_first: valid=%b data=%0d, required 1/10", bus.out_valid, $signed(bus.out_data));
                end
            end
        end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd20 || bus.fifo_level !== 3'd1) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b data=%0d level=%0d, required 1/20/1",
                     bus.out_valid, $signed(bus.out_data), bus.fifo_level);
        end
        cyc(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset(2);
        for (int k = 1; k <= 5; k++) repeat (4) cyc(1'b1, k, 1'b0, 1'b0);
        n_tests++;
        if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_fill: level=%0d ovf=%b, required 4/1", bus.fifo_level, bus.overflow);
        end
        for (int k = 1; k <= 4; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(k)) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: valid=%b data=%0d, required 1/%0d", k, bus.out_valid, $signed(bus.out_data), k);
            end
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        n_tests++;
        if (bus.fifo_level !== 3'd0 || bus.overflow !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'd4) begin
            n_fail++;
            $display("FAIL ovf_drained: level=%0d ovf=%b valid=%b data=%0d, required 0/1/0/4",
                     bus.fifo_level, bus.overflow, bus.out_valid, $signed(bus.out_data));
        end
    endtask

    task automatic test_full_pop();
        do_reset(2);
        for (int k = 1; k <= 4; k++) repeat (4) cyc(1'b1, k, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 5, 1'b0, 1'b0);
        cyc(1'b1, 5, 1'b1, 1'b0);
        n_tests++;
        if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0 || bus.out_data !== 16'd2) begin
            n_fail++;
            $display("FAIL full_pushpop: level=%0d ovf=%b data=%0d, required 4/0/2",
                     bus.fifo_level, bus.overflow, $signed(bus.out_data));
        end
        repeat (4) cyc(1'b1, 6, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        n_tests++;
        if (bus.overflow !== 1'b0 || bus.fifo_level !== 3'd4) begin
            n_fail++;
            $display("FAIL clear_ovf: ovf=%b level=%0d, required 0/4", bus.overflow, bus.fifo_level);
        end
        repeat (3) cyc(1'b1, 7, 1'b0, 1'b0);
        cyc(1'b1, 7, 1'b0, 1'b1);
        n_tests++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins: ovf=%b, required 1", bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        repeat (2) cyc(1'b1, 100, 1'b1, 1'b0);
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8, 1'b1, 1'b0);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd8 || bus.fifo_level !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b data=%0d level=%0d, required 1/8/1",
                     bus.out_valid, $signed(bus.out_data), bus.fifo_level);
        end
        cyc(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit v, rdy, clr;
        int d, rdy_pct;
        bit exp_valid;
        logic [15:0] exp_data;
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            rdy_pct = ((c / 300) % 2 == 0) ? 20 : 80;
            v   = ($urandom_range(0, 99) < 60);
            d   = int'($urandom_range(0, 65535)) - 32768;
            rdy = ($urandom_range(0, 99) < rdy_pct);
            clr = ($urandom_range(0, 99) < 3);
            cyc(v, d, rdy, clr);
            exp_valid = (m_q.size() > 0);
            exp_data  = exp_valid ? 16'(m_q[0]) : 16'(m_last);
            n_tests++;
            if (bus.out_valid !== exp_valid || bus.out_data !== exp_data ||
                bus.fifo_level !== 3'(m_q.size()) || bus.overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random_c%0d: valid=%b data=%0d level=%0d ovf=%b, required %b/%0d/%0d/%b",
                         c, bus.out_valid, $signed(bus.out_data), bus.fifo_level, bus.overflow,
                         exp_valid, $signed(exp_data), m_q.size(), m_ovf);
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.out_ready      = 1'b0;
        bus.clear_overflow = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
